// File: rtl/dnn_input_streamer.sv
// Double-buffered input streamer: the host fills one bank beat by beat while the
// other bank is replayed to the network chunk by chunk, one sample per cycle block.
`timescale 1ns/1ps
module dnn_input_streamer #(
    parameter int n0  = 16,
    parameter int z0  = 8,
    parameter int fo0 = 2,
    parameter int nL  = 4,
    parameter int zL  = 4,
    parameter int fiL = 4,
    parameter int cpc = n0 * fo0 / z0 + 2,
    localparam int AW  = 8 * z0 / fo0,
    localparam int ACH = n0 * fo0 / z0,
    localparam int YW  = zL / fiL,
    localparam int YCH = nL / YW,
    localparam int CIW = $clog2(cpc)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [CIW-1:0] cycle_index,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [AW-1:0]  s_data,
    input  logic [nL-1:0]  s_label,
    output logic [AW-1:0]  a_in,
    output logic [YW-1:0]  y_in,
    output logic           underrun,
    output logic [15:0]    sample_count
);
    localparam int BW = (ACH > 1) ? $clog2(ACH) : 1;

    if (ACH > cpc - 2 || YCH > cpc) begin : g_bad_cfg
        $error("dnn_input_streamer: ACH or YCH does not fit in one cycle block");
    end

    typedef enum logic [1:0] {
        BANK_EMPTY  = 2'd0,
        BANK_FULL   = 2'd1,
        BANK_ACTIVE = 2'd2
    } bank_state_e;

    bank_state_e   state_q [2];
    bank_state_e   state_d [2];
    logic [AW-1:0] chunk_q [2][ACH];
    logic [AW-1:0] chunk_d [2][ACH];
    logic [nL-1:0] label_q [2];
    logic [nL-1:0] label_d [2];
    logic          wr_sel_q;
    logic          wr_sel_d;
    logic          rd_sel_q;
    logic          rd_sel_d;
    logic [BW-1:0] beat_q;
    logic [BW-1:0] beat_d;
    logic          underrun_q;
    logic          underrun_d;
    logic [15:0]   count_q;
    logic [15:0]   count_d;
    logic          boundary_s;
    logic          accept_s;
    logic          next_rd_s;
    logic          bank_active_s;
    logic [nL-1:0] label_shift_s;

    // Next-state: block boundary retires/activates banks, accepted beats fill the write bank
    always_comb begin
        boundary_s = (cycle_index == CIW'(cpc - 1));
        accept_s   = s_valid && (state_q[wr_sel_q] == BANK_EMPTY);
        state_d    = state_q;
        chunk_d    = chunk_q;
        label_d    = label_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        beat_d     = beat_q;
        underrun_d = 1'b0;
        count_d    = count_q;
        next_rd_s  = rd_sel_q;

        // The read pointer advances when a block retires; eligibility uses pre-edge state
        if (boundary_s) begin
            if (state_q[rd_sel_q] == BANK_ACTIVE) begin
                state_d[rd_sel_q] = BANK_EMPTY;
                next_rd_s         = ~rd_sel_q;
            end else begin
                next_rd_s         = rd_sel_q;
            end
            rd_sel_d = next_rd_s;
            if (state_q[next_rd_s] == BANK_FULL) begin
                state_d[next_rd_s] = BANK_ACTIVE;
                count_d            = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            end else begin
                underrun_d         = 1'b1;
            end
        end else begin
            underrun_d = 1'b0;
        end

        if (accept_s) begin
            chunk_d[wr_sel_q][beat_q] = s_data;
            if (beat_q == BW'(ACH - 1)) begin
                label_d[wr_sel_q] = s_label;
                state_d[wr_sel_q] = BANK_FULL;
                beat_d            = {BW{1'b0}};
                wr_sel_d          = ~wr_sel_q;
            end else begin
                beat_d            = beat_q + BW'(1);
            end
        end else begin
            beat_d = beat_q;
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            beat_q     <= {BW{1'b0}};
            underrun_q <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            beat_q     <= beat_d;
            underrun_q <= underrun_d;
            count_q    <= count_d;
        end
    end

    // Bank payload storage; contents are qualified by bank state so no reset is needed
    always_ff @(posedge clk) begin
        chunk_q <= chunk_d;
        label_q <= label_d;
    end

    // Zero-latency replay of the active bank, indexed by position in the block
    always_comb begin
        bank_active_s = (state_q[rd_sel_q] == BANK_ACTIVE);
        label_shift_s = label_q[rd_sel_q] >> (int'(cycle_index) * YW);
        if (bank_active_s && int'(cycle_index) < ACH) begin
            a_in = chunk_q[rd_sel_q][cycle_index[BW-1:0]];
        end else begin
            a_in = {AW{1'b0}};
        end
        if (bank_active_s && int'(cycle_index) < YCH) begin
            y_in = label_shift_s[YW-1:0];
        end else begin
            y_in = {YW{1'b0}};
        end
    end

    assign s_ready      = (state_q[wr_sel_q] == BANK_EMPTY);
    assign underrun     = underrun_q;
    assign sample_count = count_q;

endmodule

// File: tb/tb_dnn_input_streamer.sv
// Bench for dnn_input_streamer: queue-based sample model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_dnn_input_streamer;
    localparam int CPC = 6;
    localparam int AW  = 32;
    localparam int ACH = 4;
    localparam int NL  = 4;
    localparam int YW  = 1;
    localparam int YCH = 4;
    localparam int CIW = 3;

    logic           clk;
    logic           reset;
    logic [CIW-1:0] cycle_index;
    logic           s_valid;
    logic           s_ready;
    logic [AW-1:0]  s_data;
    logic [NL-1:0]  s_label;
    logic [AW-1:0]  a_in;
    logic [YW-1:0]  y_in;
    logic           underrun;
    logic [15:0]    sample_count;

    dnn_input_streamer #(
        .n0(16), .z0(8), .fo0(2), .nL(4), .zL(4), .fiL(4), .cpc(6)
    ) dut (
        .clk(clk), .reset(reset), .cycle_index(cycle_index),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_label(s_label),
        .a_in(a_in), .y_in(y_in), .underrun(underrun), .sample_count(sample_count)
    );

    typedef struct packed {
        logic [NL-1:0]          lab;
        logic [ACH-1:0][AW-1:0] ch;
    } sample_t;

    // Model: samples waiting to stream, the one streaming now, and a partial fill
    sample_t full_q[$];
    sample_t m_cur;
    sample_t m_part;
    bit      m_act;
    bit      m_und;
    int      m_beats;
    int      m_cnt;

    int n_vec;
    int n_err;
    bit chk_en;
    bit acc;
    bit und_track;
    int und_seen;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic model_clear();
        full_q.delete();
        m_act   = 1'b0;
        m_und   = 1'b0;
        m_beats = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step();
        bit rdy;
        if (reset) begin
            model_clear();
            return;
        end
        rdy   = (full_q.size() + int'(m_act)) < 2;
        m_und = 1'b0;
        if (cycle_index == CIW'(CPC - 1)) begin
            m_act = 1'b0;
            if (full_q.size() > 0) begin
                m_cur = full_q.pop_front();
                m_act = 1'b1;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_und = 1'b1;
            end
        end
        if (s_valid && rdy) begin
            m_part.ch[m_beats] = s_data;
            m_beats++;
            if (m_beats == ACH) begin
                m_part.lab = s_label;
                full_q.push_back(m_part);
                m_beats = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare process: every negedge, all outputs against the model
    initial begin
        logic [AW-1:0] ea;
        logic [YW-1:0] ey;
        bit            er;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                ea = '0;
                ey = '0;
                if (m_act && int'(cycle_index) < ACH) ea = m_cur.ch[int'(cycle_index)];
                if (m_act && int'(cycle_index) < YCH) ey = m_cur.lab[int'(cycle_index) * YW +: YW];
                er = (full_q.size() + int'(m_act)) < 2;
                check("a_in", 64'(a_in), 64'(ea));
                check("y_in", 64'(y_in), 64'(ey));
                check("s_ready", 64'(s_ready), 64'(er));
                check("underrun", 64'(underrun), 64'(m_und));
                check("sample_count", 64'(sample_count), 64'(m_cnt));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        acc = s_valid && s_ready;
        @(posedge clk);
        #2;
        cycle_index = (cycle_index == CIW'(CPC - 1)) ? '0 : cycle_index + CIW'(1);
        if (und_track && m_cnt >= 1 && underrun) und_seen++;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        model_clear();
        #1;
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_a_in", 64'(a_in), 64'd0);
        check("rst_y_in", 64'(y_in), 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);
        check("rst_count", 64'(sample_count), 64'd0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push_sample(input sample_t smp, input bit rnd, output bit stalled);
        stalled = 1'b0;
        for (int b = 0; b < ACH; b++) begin
            int tries;
            tries = 0;
            do begin
                if (rnd && $urandom_range(0, 9) < 3) begin
                    s_valid = 1'b0;
                    s_data  = $urandom;
                    s_label = NL'($urandom);
                end else begin
                    s_valid = 1'b1;
                    s_data  = smp.ch[b];
                    s_label = smp.lab;
                end
                tick();
                if (!acc) stalled = 1'b1;
                tries++;
            end while (!acc && tries < 200);
            if (!acc) begin
                n_vec++;
                n_err++;
                $display("FAIL push_timeout: got no accept, expected accept on beat %0d", b);
            end
        end
    endtask

    function automatic sample_t rand_sample();
        sample_t s;
        for (int k = 0; k < ACH; k++) s.ch[k] = $urandom;
        s.lab = NL'(1) << $urandom_range(0, NL - 1);
        return s;
    endfunction

    task automatic wait_block_start();
        while (cycle_index != CIW'(CPC - 1)) tick();
        tick();
    endtask

    initial begin
        logic [AW-1:0] lit_a [ACH];
        logic [YW-1:0] lit_y [YCH];
        sample_t       sa, sb, sc, sn;
        bit            st;
        int            pulses;

        lit_a = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        lit_y = '{1'b0, 1'b0, 1'b1, 1'b0};
        n_vec = 0; n_err = 0; chk_en = 1'b0; und_track = 1'b0; und_seen = 0;
        reset = 1'b1; s_valid = 1'b0; s_data = '0; s_label = '0; cycle_index = '0;
        model_clear();
        #2;
        chk_en = 1'b1;

        // One sample with literal replay values
        do_reset();
        for (int k = 0; k < ACH; k++) sa.ch[k] = lit_a[k];
        sa.lab = 4'b0100;
        push_sample(sa, 1'b0, st);
        s_valid = 1'b0;
        wait_block_start();
        for (int k = 0; k < ACH; k++) begin
            #1;
            check("lit_a_in", 64'(a_in), 64'(lit_a[k]));
            check("lit_y_in", 64'(y_in), 64'(lit_y[k]));
            check("lit_count", 64'(sample_count), 64'd1);
            tick();
        end

        // No samples: one underrun pulse per block
        do_reset();
        pulses = 0;
        repeat (3 * CPC) begin
            tick();
            #1;
            if (underrun) pulses++;
        end
        check("underrun_pulses", 64'(pulses), 64'd3);

        // Back-to-back A, B, C: C stalls until A's block retires
        do_reset();
        sa = rand_sample(); sb = rand_sample(); sc = rand_sample();
        push_sample(sa, 1'b0, st);
        push_sample(sb, 1'b0, st);
        push_sample(sc, 1'b0, st);
        s_valid = 1'b0;
        check("abc_c_stalled", 64'(st), 64'd1);
        repeat (4 * CPC) tick();
        #1;
        check("abc_count", 64'(sample_count), 64'd3);

        // Sample completing on the boundary edge streams one block later
        do_reset();
        while (cycle_index != CIW'(CPC - 4)) tick();
        sn = rand_sample();
        push_sample(sn, 1'b0, st);
        s_valid = 1'b0;
        #1;
        check("late_underrun", 64'(underrun), 64'd1);
        check("late_a_in_zero", 64'(a_in), 64'd0);
        wait_block_start();
        #1;
        check("late_a_in", 64'(a_in), 64'(sn.ch[0]));
        check("late_count", 64'(sample_count), 64'd1);
        tick();

        // Reset mid-block, then mid-fill: partial sample is discarded
        do_reset();
        for (int b = 0; b < 2; b++) begin
            s_valid = 1'b1;
            s_data  = 32'hDEAD0000 | AW'(b);
            tick();
        end
        s_valid = 1'b0;
        do_reset();
        sn = rand_sample();
        push_sample(sn, 1'b0, st);
        s_valid = 1'b0;
        wait_block_start();
        #1;
        check("midfill_a_in", 64'(a_in), 64'(sn.ch[0]));
        check("midfill_count", 64'(sample_count), 64'd1);
        repeat (2 * CPC) tick();
        #1;
        check("midfill_count_hold", 64'(sample_count), 64'd1);

        // Full-rate host never underruns; then random pacing
        do_reset();
        und_track = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sn = rand_sample();
            push_sample(sn, 1'b0, st);
        end
        und_track = 1'b0;
        check("fullrate_underruns", 64'(und_seen), 64'd0);
        for (int i = 0; i < 1000; i++) begin
            sn = rand_sample();
            push_sample(sn, 1'b1, st);
        end
        s_valid = 1'b0;
        repeat (4 * CPC) tick();
        #1;
        check("random_count", 64'(sample_count), 64'd1020);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
